branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Resolves branch/jump outcomes in EX against the prediction the branch target buffer gave at fetch. Produces a one-cycle flush/redirect and the BTB training writes (was_taken/jumped/target).
- Carries each fetched instruction's predicted target through a shadow pipeline aligned with IF→ID→EX.
- Tracks prediction statistics.

Parameters:
- PIPE_DEPTH, 2: register stages between fetch and EX (≥1).
- RECOVER_CYCLES, 2: cycles EX results are ignored after a redirect (wrong-path drain).
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  freezes the shadow pipeline; EX results are not consumed
- if_valid  in  1  fetch slot holds a real instruction
- if_pc  in  64  fetch PC
- if_pred_pc  in  64  BTB prediction for if_pc (0 = no prediction)
- ex_is_branch  in  1  EX holds a conditional branch
- ex_taken  in  1  branch condition true
- ex_branch_pc  in  64  computed branch target
- ex_is_jump  in  1  EX holds an unconditional jump
- ex_jump_pc  in  64  computed jump target
- flush  out  1  registered pulse: squash IF/ID
- redirect_pc  out  64  fetch restart PC, valid with flush
- upd_en  out  1  BTB write strobe
- upd_pc  out  64  PC of the resolved instruction (BTB prev_pc)
- upd_target  out  64  target written (0 = invalidate)
- upd_was_taken  out  1  conditional-branch training
- upd_jumped  out  1  jump training
- n_ctrl  out  CNT_W  resolved control instructions
- n_mispred  out  CNT_W  mispredictions

Behaviour:
- Reset: all outputs 0; shadow valids 0; FSM to RUN. Reset takes priority over stall.
- Shadow pipeline:
  - PIPE_DEPTH entries of {valid, pc, pred_pc}.
  - When stall=0, entries shift by one per cycle; entry 0 loads {if_valid, if_pc, if_pred_pc}.
  - When stall=1, all entries hold.
  - The last entry is the EX entry.
- Resolution (EX entry valid, stall=0, FSM=RUN):
  - actual_taken = (ex_is_branch & ex_taken) | ex_is_jump.
  - actual_tgt = ex_is_jump ? ex_jump_pc : ex_branch_pc (jump wins if both asserted).
  - Mispredict A: actual_taken and pred_pc != actual_tgt. Redirect to actual_tgt, upd_target = actual_tgt.
  - Mispredict B: !actual_taken and pred_pc != 0. Redirect to pc+4 (64-bit wrap), upd_target = 0.
  - Otherwise correct: no flush, no update.
- Output timing: every mispredict registers flush=1, redirect_pc and upd_en=1 in the next cycle (latency 1). All are single-cycle pulses.
  - upd_pc = EX pc.
  - upd_was_taken = ex_is_branch & ex_taken.
  - upd_jumped = ex_is_jump.
- Flush side effects: on the cycle flush is registered, all shadow valids clear. Clearing overrides a concurrent shift/load.
- FSM:
  - RUN → RECOVER on mispredict; load recover counter with RECOVER_CYCLES.
  - RECOVER: decrement the counter each non-stalled cycle; EX results ignored; no flush, no upd_en, no counting. Return to RUN when the counter reaches 0.
  - Stall in RECOVER holds the counter.
- Counters:
  - n_ctrl increments per resolved branch/jump in RUN.
  - n_mispred increments per mispredict.
  - Both saturate at all-ones, never wrap.
- Invalid EX entry: EX inputs are ignored, even if asserted.
- Simultaneous stall and mispredict: stall wins. Resolution is deferred until the first non-stalled cycle; the EX entry is held.

Decomposition:
- Shared package (branch_pkg):
  - PC_W=64, INSN_BYTES=4
  - FSM state encoding: RUN, RECOVER
  - shadow-entry struct/field widths.
- One natural sub-module: sat_counter (parameterised width, inc, rst, saturating). Instantiated twice.

Test Plan:
- Correct taken: if_pc=0x100, if_pred_pc=0x200. Two cycles later ex_is_branch=1, ex_taken=1, ex_branch_pc=0x200 → flush=0, upd_en=0, n_ctrl=1, n_mispred=0.
- Cold miss: pred 0, jump to 0x400 at pc 0x100 → next cycle flush=1, redirect_pc=0x400, upd_pc=0x100, upd_target=0x400, upd_jumped=1; shadow valids cleared.
- False taken: pred 0x200, branch not taken at pc 0x1FC → redirect_pc=0x200, upd_target=0, upd_was_taken=0, n_mispred=1.
- Recovery drain: a mispredict is followed by two wrong-path taken branches with mismatched targets → no flush/upd in those RECOVER_CYCLES=2 cycles; the third resolves normally.
- Stall hold: stall=1 for 3 cycles with a mispredicting EX entry → flush only in the cycle after stall drops; redirect_pc correct.
- Edge cases:
  - pc=0xFFFF_FFFF_FFFF_FFFC not taken with pred≠0 → redirect_pc=0x0.
  - Preset n_mispred=all-ones (CNT_W=4 build) → stays 0xF.
  - rst mid-RECOVER → all outputs 0, FSM RUN next cycle.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution slice.
//   PC_W / INSN_BYTES : address width and fixed instruction size
//   bru_state_t       : resolver FSM encoding (RUN, RECOVER)
//   shadow_entry_t    : one stage of the prediction shadow pipeline
//   next_seq_pc()     : fall-through PC (wraps at 2^PC_W)
package branch_pkg;

    localparam int PC_W       = 64;
    localparam int INSN_BYTES = 4;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bru_state_t;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pred_pc;
    } shadow_entry_t;

    function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(INSN_BYTES);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear
//   inc   : add one this cycle (ignored once the count is all-ones)
//   count : current value
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: compares the EX-stage outcome of a branch/jump with
// the BTB prediction captured at fetch, and emits a one-cycle flush/redirect
// plus BTB training write on a mispredict.
//   clk, rst                      : clock / synchronous active-high reset
//   stall                         : freeze shadow pipeline, defer resolution
//   if_valid, if_pc, if_pred_pc   : fetch slot and its BTB prediction
//   ex_is_branch, ex_taken,
//   ex_branch_pc, ex_is_jump,
//   ex_jump_pc                    : EX-stage resolved control-flow info
//   flush, redirect_pc            : registered squash pulse and restart PC
//   upd_en, upd_pc, upd_target,
//   upd_was_taken, upd_jumped     : registered BTB training write
//   n_ctrl, n_mispred             : saturating statistics
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int PIPE_DEPTH     = 2,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [PC_W-1:0]  if_pc,
    input  logic [PC_W-1:0]  if_pred_pc,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_branch_pc,
    input  logic             ex_is_jump,
    input  logic [PC_W-1:0]  ex_jump_pc,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             upd_en,
    output logic [PC_W-1:0]  upd_pc,
    output logic [PC_W-1:0]  upd_target,
    output logic             upd_was_taken,
    output logic             upd_jumped,
    output logic [CNT_W-1:0] n_ctrl,
    output logic [CNT_W-1:0] n_mispred
);

    localparam int RC_W = $clog2(RECOVER_CYCLES + 1);

    // ------------------------------------------------------------------
    // Shadow pipeline: follows each fetched instruction to EX so its
    // prediction is available at resolution time.
    // ------------------------------------------------------------------
    shadow_entry_t shadow_in  [PIPE_DEPTH];
    shadow_entry_t shadow_out [PIPE_DEPTH];
    shadow_entry_t ex_entry;
    logic          mispredict;

    assign shadow_in[0] = '{valid: if_valid, pc: if_pc, pred_pc: if_pred_pc};

    generate
        for (genvar gi = 1; gi < PIPE_DEPTH; gi++) begin : g_chain
            assign shadow_in[gi] = shadow_out[gi-1];
        end

        for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
            shadow_entry_t entry_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (!stall) begin
                    entry_reg.pc      <= shadow_in[gi].pc;
                    entry_reg.pred_pc <= shadow_in[gi].pred_pc;
                    // Everything in flight behind a mispredict is wrong-path.
                    entry_reg.valid   <= shadow_in[gi].valid & ~mispredict;
                end
            end

            assign shadow_out[gi] = entry_reg;
        end
    endgenerate

    assign ex_entry = shadow_out[PIPE_DEPTH-1];

    // ------------------------------------------------------------------
    // Resolution
    // ------------------------------------------------------------------
    bru_state_t      state_reg, state_next;
    logic [RC_W-1:0] rc_cnt_reg, rc_cnt_next;

    logic            actual_taken;
    logic [PC_W-1:0] actual_tgt;
    logic            resolve;
    logic            mis_taken;
    logic            mis_fallthru;

    assign actual_taken = (ex_is_branch & ex_taken) | ex_is_jump;
    assign actual_tgt   = ex_is_jump ? ex_jump_pc : ex_branch_pc;
    assign resolve      = ex_entry.valid & ~stall & (state_reg == RUN);

    // Taken with a wrong (or missing) target, or predicted taken but fell through.
    assign mis_taken    = actual_taken & (ex_entry.pred_pc != actual_tgt);
    assign mis_fallthru = ~actual_taken & (ex_entry.pred_pc != '0);
    assign mispredict   = resolve & (mis_taken | mis_fallthru);

    // ------------------------------------------------------------------
    // Recovery FSM: ignore EX for RECOVER_CYCLES non-stalled cycles
    // after a redirect while wrong-path work drains.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= RUN;
            rc_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            rc_cnt_reg <= rc_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rc_cnt_next = rc_cnt_reg;
        case (state_reg)
            RUN: begin
                if (mispredict) begin
                    state_next  = RECOVER;
                    rc_cnt_next = RC_W'(RECOVER_CYCLES);
                end
            end
            RECOVER: begin
                if (!stall) begin
                    if (rc_cnt_reg <= RC_W'(1)) begin
                        state_next  = RUN;
                        rc_cnt_next = '0;
                    end else begin
                        rc_cnt_next = rc_cnt_reg - RC_W'(1);
                    end
                end
            end
            default: begin
                state_next  = RUN;
                rc_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered redirect / BTB training pulse. Non-pulse cycles drive
    // zero on every field so stale values never leak out.
    // ------------------------------------------------------------------
    logic            flush_reg;
    logic [PC_W-1:0] redirect_pc_reg;
    logic            upd_en_reg;
    logic [PC_W-1:0] upd_pc_reg;
    logic [PC_W-1:0] upd_target_reg;
    logic            upd_was_taken_reg;
    logic            upd_jumped_reg;

    always_ff @(posedge clk) begin
        if (rst || !mispredict) begin
            flush_reg         <= 1'b0;
            redirect_pc_reg   <= '0;
            upd_en_reg        <= 1'b0;
            upd_pc_reg        <= '0;
            upd_target_reg    <= '0;
            upd_was_taken_reg <= 1'b0;
            upd_jumped_reg    <= 1'b0;
        end else begin
            flush_reg         <= 1'b1;
            upd_en_reg        <= 1'b1;
            upd_pc_reg        <= ex_entry.pc;
            upd_was_taken_reg <= ex_is_branch & ex_taken;
            upd_jumped_reg    <= ex_is_jump;
            if (mis_taken) begin
                redirect_pc_reg <= actual_tgt;
                upd_target_reg  <= actual_tgt;
            end else begin
                // Predicted-taken fall-through: restart sequentially and
                // invalidate the BTB entry.
                redirect_pc_reg <= next_seq_pc(ex_entry.pc);
                upd_target_reg  <= '0;
            end
        end
    end

    assign flush         = flush_reg;
    assign redirect_pc   = redirect_pc_reg;
    assign upd_en        = upd_en_reg;
    assign upd_pc        = upd_pc_reg;
    assign upd_target    = upd_target_reg;
    assign upd_was_taken = upd_was_taken_reg;
    assign upd_jumped    = upd_jumped_reg;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    sat_counter #(.WIDTH(CNT_W)) u_ctrl_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (resolve & (ex_is_branch | ex_is_jump)),
        .count (n_ctrl)
    );

    sat_counter #(.WIDTH(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mispredict),
        .count (n_mispred)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
    import branch_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             if_valid;
    logic [63:0]      if_pc;
    logic [63:0]      if_pred_pc;
    logic             ex_is_branch;
    logic             ex_taken;
    logic [63:0]      ex_branch_pc;
    logic             ex_is_jump;
    logic [63:0]      ex_jump_pc;
    logic             flush;
    logic [63:0]      redirect_pc;
    logic             upd_en;
    logic [63:0]      upd_pc;
    logic [63:0]      upd_target;
    logic             upd_was_taken;
    logic             upd_jumped;
    logic [CNT_W-1:0] n_ctrl;
    logic [CNT_W-1:0] n_mispred;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .PIPE_DEPTH     (2),
        .RECOVER_CYCLES (2),
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_pred_pc    (if_pred_pc),
        .ex_is_branch  (ex_is_branch),
        .ex_taken      (ex_taken),
        .ex_branch_pc  (ex_branch_pc),
        .ex_is_jump    (ex_is_jump),
        .ex_jump_pc    (ex_jump_pc),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .upd_en        (upd_en),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_was_taken (upd_was_taken),
        .upd_jumped    (upd_jumped),
        .n_ctrl        (n_ctrl),
        .n_mispred     (n_mispred)
    );

    typedef struct {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] pred;
        logic        is_br;
        logic        taken;
        logic [63:0] br_pc;
        logic        is_j;
        logic [63:0] j_pc;
        logic        exp_flush;
        logic [63:0] exp_redirect;
        logic [63:0] exp_target;
    } vec_t;

    typedef struct {
        logic        flush;
        logic [63:0] redirect;
        logic        upd_en;
        logic [63:0] upd_pc;
        logic [63:0] upd_target;
        logic        was_taken;
        logic        jumped;
    } out_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];
    out_t sb_q [$];
    int   total = 0;
    int   bad   = 0;
    int   m_ctrl = 0;
    int   m_mis  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_valid     = 1'b0;
        if_pc        = '0;
        if_pred_pc   = '0;
        ex_is_branch = 1'b0;
        ex_taken     = 1'b0;
        ex_branch_pc = '0;
        ex_is_jump   = 1'b0;
        ex_jump_pc   = '0;
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    function automatic out_t zero_out();
        out_t o;
        o = '{flush: 1'b0, redirect: 64'h0, upd_en: 1'b0, upd_pc: 64'h0,
              upd_target: 64'h0, was_taken: 1'b0, jumped: 1'b0};
        return o;
    endfunction

    function automatic out_t mis_out(input logic [63:0] redir, input logic [63:0] pc,
                                     input logic [63:0] tgt, input logic wt, input logic jmp);
        out_t o;
        o = '{flush: 1'b1, redirect: redir, upd_en: 1'b1, upd_pc: pc,
              upd_target: tgt, was_taken: wt, jumped: jmp};
        return o;
    endfunction

    // Pop the oldest expectation and compare it against the registered outputs.
    task automatic check_out(input string tag);
        out_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb_q.pop_front();
        check64({tag, ".flush"},      64'(flush),         64'(e.flush));
        check64({tag, ".redirect"},   redirect_pc,        e.redirect);
        check64({tag, ".upd_en"},     64'(upd_en),        64'(e.upd_en));
        check64({tag, ".upd_pc"},     upd_pc,             e.upd_pc);
        check64({tag, ".upd_target"}, upd_target,         e.upd_target);
        check64({tag, ".was_taken"},  64'(upd_was_taken), 64'(e.was_taken));
        check64({tag, ".jumped"},     64'(upd_jumped),    64'(e.jumped));
        check64({tag, ".n_ctrl"},     64'(n_ctrl),        64'(m_ctrl));
        check64({tag, ".n_mispred"},  64'(n_mispred),     64'(m_mis));
        $display("txn %s: flush=%0d redirect=%0h upd_en=%0d upd_pc=%0h upd_target=%0h wt=%0d j=%0d n_ctrl=%0d n_mispred=%0d",
                 tag, flush, redirect_pc, upd_en, upd_pc, upd_target, upd_was_taken,
                 upd_jumped, n_ctrl, n_mispred);
    endtask

    // Fetch one instruction, resolve it two cycles later, check, then
    // confirm the pulse dropped.
    task automatic run_vec(input vec_t v, input string tag);
        out_t e;
        idle_inputs();
        if_valid   = v.valid;
        if_pc      = v.pc;
        if_pred_pc = v.pred;
        step();
        idle_inputs();
        step();
        ex_is_branch = v.is_br;
        ex_taken     = v.taken;
        ex_branch_pc = v.br_pc;
        ex_is_jump   = v.is_j;
        ex_jump_pc   = v.j_pc;
        if (v.exp_flush)
            e = mis_out(v.exp_redirect, v.pc, v.exp_target, v.is_br & v.taken, v.is_j);
        else
            e = zero_out();
        sb_q.push_back(e);
        if (v.valid && (v.is_br || v.is_j)) m_ctrl = sat_inc(m_ctrl);
        if (v.exp_flush) m_mis = sat_inc(m_mis);
        step();
        idle_inputs();
        check_out(tag);
        step();
        check64({tag, ".pulse_end"}, 64'({flush, upd_en}), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            valid pc                      pred          br  tk  br_pc     j   j_pc      flush redirect  target
        vecs[0]  = '{1'b1, 64'h100,                64'h200,      1'b1, 1'b1, 64'h200, 1'b0, 64'h0,    1'b0, 64'h0,   64'h0};
        vecs[1]  = '{1'b1, 64'h100,                64'h0,        1'b0, 1'b0, 64'h0,   1'b1, 64'h400,  1'b1, 64'h400, 64'h400};
        vecs[2]  = '{1'b1, 64'h1FC,                64'h200,      1'b1, 1'b0, 64'h300, 1'b0, 64'h0,    1'b1, 64'h200, 64'h0};
        vecs[3]  = '{1'b1, 64'h300,                64'h0,        1'b1, 1'b0, 64'h380, 1'b0, 64'h0,    1'b0, 64'h0,   64'h0};
        vecs[4]  = '{1'b1, 64'h500,                64'h600,      1'b1, 1'b1, 64'h700, 1'b1, 64'h600,  1'b0, 64'h0,   64'h0};
        vecs[5]  = '{1'b1, 64'h500,                64'h700,      1'b1, 1'b1, 64'h700, 1'b1, 64'h600,  1'b1, 64'h600, 64'h600};
        vecs[6]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10,      1'b1, 1'b0, 64'h20,  1'b0, 64'h0,    1'b1, 64'h0,   64'h0};
        vecs[7]  = '{1'b1, 64'h800,                64'h900,      1'b0, 1'b0, 64'h0,   1'b0, 64'h0,    1'b1, 64'h804, 64'h0};
        vecs[8]  = '{1'b1, 64'h40,                 64'h80,       1'b1, 1'b1, 64'h90,  1'b0, 64'h0,    1'b1, 64'h90,  64'h90};
        vecs[9]  = '{1'b1, 64'h1000,               64'h2000,     1'b0, 1'b0, 64'h0,   1'b1, 64'h2000, 1'b0, 64'h0,   64'h0};
        vecs[10] = '{1'b0, 64'h100,                64'h0,        1'b0, 1'b0, 64'h0,   1'b1, 64'h400,  1'b0, 64'h0,   64'h0};

        // Reset, with stall held high to show reset wins.
        idle_inputs();
        rst   = 1'b1;
        stall = 1'b1;
        step();
        step();
        sb_q.push_back(zero_out());
        check_out("reset");
        rst   = 1'b0;
        stall = 1'b0;
        step();

        // Table, three passes: the 4-bit counters saturate along the way.
        for (int pass = 0; pass < 3; pass++) begin
            for (int i = 0; i < NVEC; i++) begin
                run_vec(vecs[i], $sformatf("vec%0d.p%0d", i, pass));
            end
        end
        check64("sat.n_mispred", 64'(n_mispred), 64'hF);

        // Reset while in RECOVER.
        run_vec(vecs[1], "pre_rst_mis");
        idle_inputs();
        if_valid = 1'b1; if_pc = 64'h100; if_pred_pc = 64'h0;
        step();
        idle_inputs();
        step();
        ex_is_jump = 1'b1; ex_jump_pc = 64'h400;
        sb_q.push_back(mis_out(64'h400, 64'h100, 64'h400, 1'b0, 1'b1));
        m_ctrl = sat_inc(m_ctrl);
        m_mis  = sat_inc(m_mis);
        step();
        idle_inputs();
        check_out("rst_mid.mis");
        rst   = 1'b1;
        stall = 1'b1;
        step();
        m_ctrl = 0;
        m_mis  = 0;
        sb_q.push_back(zero_out());
        check_out("rst_mid.zero");
        rst   = 1'b0;
        stall = 1'b0;
        step();
        run_vec(vecs[8], "rst_mid.after");

        // Recovery drain with a continuous fetch stream.
        idle_inputs();
        if_valid = 1'b1; if_pc = 64'h100; if_pred_pc = 64'h0;
        step();
        if_pc = 64'h104; if_pred_pc = 64'h999;
        step();
        if_pc = 64'h108; if_pred_pc = 64'h0;
        ex_is_jump = 1'b1; ex_jump_pc = 64'h400;
        sb_q.push_back(mis_out(64'h400, 64'h100, 64'h400, 1'b0, 1'b1));
        m_ctrl = sat_inc(m_ctrl);
        m_mis  = sat_inc(m_mis);
        step();
        check_out("drain.mis");
        if_pc = 64'h200; if_pred_pc = 64'h0;
        ex_is_jump = 1'b0; ex_is_branch = 1'b1; ex_taken = 1'b1; ex_branch_pc = 64'h777;
        sb_q.push_back(zero_out());
        step();
        check_out("drain.rec1");
        if_valid = 1'b0;
        ex_branch_pc = 64'h888;
        sb_q.push_back(zero_out());
        step();
        check_out("drain.rec2");
        idle_inputs();
        ex_is_jump = 1'b1; ex_jump_pc = 64'h500;
        sb_q.push_back(mis_out(64'h500, 64'h200, 64'h500, 1'b0, 1'b1));
        m_ctrl = sat_inc(m_ctrl);
        m_mis  = sat_inc(m_mis);
        step();
        idle_inputs();
        check_out("drain.third");
        step();
        step();

        // Stall hold over a mispredicting EX entry.
        if_valid = 1'b1; if_pc = 64'h300; if_pred_pc = 64'h0;
        step();
        idle_inputs();
        step();
        ex_is_jump = 1'b1; ex_jump_pc = 64'h340;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back(zero_out());
            step();
            check_out($sformatf("stall.hold%0d", k));
        end
        stall = 1'b0;
        sb_q.push_back(mis_out(64'h340, 64'h300, 64'h340, 1'b0, 1'b1));
        m_ctrl = sat_inc(m_ctrl);
        m_mis  = sat_inc(m_mis);
        step();
        idle_inputs();
        check_out("stall.release");
        step();
        check64("stall.pulse_end", 64'({flush, upd_en}), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
